comp_move_engine: RTL

Automatic computer-opponent move generator that sits directly upstream of the game core. It drives the core's comp_pos/pc inputs.
- On a start request it snapshots the 9-cell board from the position registers.
- It scans the board sequentially, one winning line per cycle, looking first for a computer win, then for a player block, then for a fixed preference order.
- It presents a single selected cell index with a one-cycle valid pulse.

---
 rtl/comp_move_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/comp_move_engine.sv
// Computer-opponent move generator: snapshots the board on start, scans the eight
// winning lines for a computer win, then a player block, then falls back to a fixed preference.
module comp_move_engine #(
  parameter logic [1:0] COMP_CODE    = 2'b10,
  parameter logic [1:0] PLYR_CODE    = 2'b01,
  parameter bit         ENABLE_BLOCK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] board,
  output logic        busy,
  output logic        move_valid,
  output logic [3:0]  move_pos,
  output logic [1:0]  move_kind,
  output logic        no_move
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN_WIN,
    SCAN_BLOCK,
    PICK,
    DONE
  } state_t;

  localparam logic [1:0] KIND_WIN   = 2'd0;
  localparam logic [1:0] KIND_BLOCK = 2'd1;
  localparam logic [1:0] KIND_PICK  = 2'd2;
  localparam logic [1:0] KIND_NONE  = 2'd3;

  state_t      r_state, w_next;
  logic [17:0] r_snap;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [3:0]  r_pos, w_pos_nxt;
  logic [1:0]  r_kind, w_kind_nxt;
  logic        r_busy, r_valid, r_nomove;

  logic [3:0]  w_a, w_b, w_c;
  logic [1:0]  w_ca, w_cb, w_cc, w_code;
  logic        w_hit;
  logic [3:0]  w_hit_pos;
  logic        w_pick_found;
  logic [3:0]  w_pick_pos;

  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] p);
    return b[2*int'(p) +: 2];
  endfunction

  // Cells of each winning line, packed as {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] idx);
    unique case (idx)
      3'd0: return {4'd0, 4'd1, 4'd2};
      3'd1: return {4'd3, 4'd4, 4'd5};
      3'd2: return {4'd6, 4'd7, 4'd8};
      3'd3: return {4'd0, 4'd3, 4'd6};
      3'd4: return {4'd1, 4'd4, 4'd7};
      3'd5: return {4'd2, 4'd5, 4'd8};
      3'd6: return {4'd0, 4'd4, 4'd8};
      3'd7: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  function automatic logic [3:0] pref_cell(input logic [3:0] i);
    case (i)
      4'd0:    return 4'd4;
      4'd1:    return 4'd0;
      4'd2:    return 4'd2;
      4'd3:    return 4'd6;
      4'd4:    return 4'd8;
      4'd5:    return 4'd1;
      4'd6:    return 4'd3;
      4'd7:    return 4'd5;
      default: return 4'd7;
    endcase
  endfunction

  // Line evaluation: the same comparator serves both scans, only the mark changes.
  always_comb begin
    {w_a, w_b, w_c} = line_cells(r_idx);
    w_ca      = cell_of(r_snap, w_a);
    w_cb      = cell_of(r_snap, w_b);
    w_cc      = cell_of(r_snap, w_c);
    w_code    = (r_state == SCAN_BLOCK) ? PLYR_CODE : COMP_CODE;
    w_hit     = 1'b0;
    w_hit_pos = w_a;
    if (w_ca == 2'b00 && w_cb == w_code && w_cc == w_code) begin
      w_hit     = 1'b1;
      w_hit_pos = w_a;
    end else if (w_cb == 2'b00 && w_ca == w_code && w_cc == w_code) begin
      w_hit     = 1'b1;
      w_hit_pos = w_b;
    end else if (w_cc == 2'b00 && w_ca == w_code && w_cb == w_code) begin
      w_hit     = 1'b1;
      w_hit_pos = w_c;
    end
  end

  always_comb begin
    w_pick_found = 1'b0;
    w_pick_pos   = 4'hF;
    for (int unsigned i = 0; i < 9; i++) begin
      if (!w_pick_found && cell_of(r_snap, pref_cell(4'(i))) == 2'b00) begin
        w_pick_found = 1'b1;
        w_pick_pos   = pref_cell(4'(i));
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_idx_nxt  = r_idx;
    w_pos_nxt  = r_pos;
    w_kind_nxt = r_kind;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next    = SCAN_WIN;
          w_idx_nxt = 3'd0;
        end
      end
      SCAN_WIN: begin
        if (w_hit) begin
          w_pos_nxt  = w_hit_pos;
          w_kind_nxt = KIND_WIN;
          w_next     = DONE;
        end else if (r_idx == 3'd7) begin
          w_idx_nxt = 3'd0;
          w_next    = ENABLE_BLOCK ? SCAN_BLOCK : PICK;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      SCAN_BLOCK: begin
        if (w_hit) begin
          w_pos_nxt  = w_hit_pos;
          w_kind_nxt = KIND_BLOCK;
          w_next     = DONE;
        end else if (r_idx == 3'd7) begin
          w_idx_nxt = 3'd0;
          w_next    = PICK;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      PICK: begin
        w_pos_nxt  = w_pick_pos;
        w_kind_nxt = w_pick_found ? KIND_PICK : KIND_NONE;
        w_next     = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Status outputs are registered off the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_snap   <= '0;
      r_idx    <= '0;
      r_pos    <= '0;
      r_kind   <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_nomove <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_idx    <= w_idx_nxt;
      r_pos    <= w_pos_nxt;
      r_kind   <= w_kind_nxt;
      r_busy   <= (w_next != IDLE);
      r_valid  <= (w_next == DONE);
      r_nomove <= (w_next == DONE) && (w_kind_nxt == KIND_NONE);
      if (r_state == IDLE && start) begin
        r_snap <= board;
      end
    end
  end

  assign busy       = r_busy;
  assign move_valid = r_valid;
  assign move_pos   = r_pos;
  assign move_kind  = r_kind;
  assign no_move    = r_nomove;

endmodule
